// File: rtl/load_store_sequencer.sv
// Load/store sequencer: splits word/half/byte accesses into little-endian byte
// transactions on a byte-wide memory port and extends load results.
module load_store_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [1:0]        memSize,
  input  logic              memSign,
  output logic              resp_valid,
  output logic [31:0]       dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       dout_q, dout_d;
  logic [2:0]        len_q, len_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       raw_q, raw_d;
  logic [1:0]        rd_idx;
  logic              accept;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] len,
                                         input logic sign);
    case (len)
      3'd1:    return sign ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
      3'd2:    return sign ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign accept = req_valid && (memWrite || memRead);
  assign dout   = dout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    len_d      = len_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    din_d      = din_q;
    raw_d      = raw_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    // Byte returned this cycle belongs to the strobe issued one cycle earlier.
    rd_idx     = 2'(cnt_q - 3'd1);
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          len_d   = size_to_len(memSize);
          addr_d  = addr;
          din_d   = din;
          sign_d  = memSign;
          raw_d   = '0;
          cnt_d   = '0;
          state_d = memWrite ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q + ADDR_W'(cnt_q);
        mem_wdata = din_q[8*cnt_q[1:0] +: 8];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_READ: begin
        mem_re   = 1'b1;
        mem_addr = addr_q + ADDR_W'(cnt_q);
        if (cnt_q != 3'd0) raw_d[8*rd_idx +: 8] = mem_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        raw_d[8*rd_idx +: 8] = mem_rdata;
        dout_d  = extend(raw_d, len_q, sign_q);
        cnt_d   = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Request payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    sign_q <= sign_d;
    addr_q <= addr_d;
    din_q  <= din_d;
    raw_q  <= raw_d;
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer against a byte-array memory with 1-cycle read latency.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] din;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  memSize;
  logic        memSign;
  logic        resp_valid;
  logic [31:0] dout;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [7:0] mem [logic [31:0]];

  load_store_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .din(din), .memWrite(memWrite), .memRead(memRead),
    .memSize(memSize), .memSign(memSign), .resp_valid(resp_valid), .dout(dout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) chk("strobe_exclusive", 32'(mem_we & mem_re), 32'd0);
  end

  task automatic do_req(input string tag, input logic we, input logic re, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic chk_dout, input logic [31:0] exp_dout);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    memWrite  = we;
    memRead   = re;
    memSize   = sz;
    memSign   = sg;
    addr      = a;
    din       = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr      = ~a;
    din       = ~d;
    memSize   = 2'b00;
    memSign   = ~sg;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      chk({tag, "_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_resp"}, 32'(resp_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (chk_dout) chk({tag, "_dout"}, dout, exp_dout);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; addr = '0; din = '0;
    memWrite = 1'b0; memRead = 1'b0; memSize = 2'b00; memSign = 1'b0;
    mem_rdata = 8'h00;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Stores then overlapping loads
    do_req("sw0", 1, 0, 2'b10, 0, 32'h0, 32'h1234_5678, 5, 0, 0);
    chk("sw0_b0", 32'(rd(0)), 32'h78);
    chk("sw0_b1", 32'(rd(1)), 32'h56);
    chk("sw0_b2", 32'(rd(2)), 32'h34);
    chk("sw0_b3", 32'(rd(3)), 32'h12);
    do_req("sh4", 1, 0, 2'b01, 0, 32'h4, 32'h1234_5678, 3, 0, 0);
    chk("sh4_b4", 32'(rd(4)), 32'h78);
    chk("sh4_b5", 32'(rd(5)), 32'h56);
    do_req("sb6", 1, 0, 2'b00, 0, 32'h6, 32'hFFFF_FFFF, 2, 0, 0);
    chk("sb6_b6", 32'(rd(6)), 32'hFF);
    chk("sb6_b7", 32'(rd(7)), 32'h00);
    do_req("lw3", 0, 1, 2'b10, 0, 32'h3, 32'h0, 6, 1, 32'hFF56_7812);
    do_req("lh5", 0, 1, 2'b01, 1, 32'h5, 32'h0, 4, 1, 32'hFFFF_FF56);
    do_req("lhu5", 0, 1, 2'b01, 0, 32'h5, 32'h0, 4, 1, 32'h0000_FF56);
    do_req("lb0", 0, 1, 2'b00, 1, 32'h0, 32'h0, 3, 1, 32'h0000_0078);
    do_req("lbu6", 0, 1, 2'b00, 0, 32'h6, 32'h0, 3, 1, 32'h0000_00FF);
    do_req("lb6", 0, 1, 2'b00, 1, 32'h6, 32'h0, 3, 1, 32'hFFFF_FFFF);
    do_req("lw11", 0, 1, 2'b11, 1, 32'h0, 32'h0, 6, 1, 32'h1234_5678);

    // Address wrap and dout hold across a store
    do_req("shwrap", 1, 0, 2'b01, 0, 32'hFFFF_FFFF, 32'h0000_ABCD, 3, 1, 32'h1234_5678);
    chk("wrap_top", 32'(rd(32'hFFFF_FFFF)), 32'hCD);
    chk("wrap_zero", 32'(rd(0)), 32'hAB);

    // Request without read/write is never accepted
    memWrite = 1'b0; memRead = 1'b0; memSize = 2'b10; addr = 32'h10; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("noop_ready", 32'(req_ready), 32'd1);
      chk("noop_resp", 32'(resp_valid), 32'd0);
      chk("noop_strobe", 32'(mem_we | mem_re), 32'd0);
    end
    req_valid = 1'b0;
    do_req("both", 1, 1, 2'b00, 0, 32'h8, 32'h0000_005A, 2, 0, 0);
    chk("both_b8", 32'(rd(8)), 32'h5A);

    // Reset during the second read strobe of a word load
    memWrite = 1'b0; memRead = 1'b1; memSize = 2'b10; memSign = 1'b0; addr = 32'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; memRead = 1'b0;
    @(posedge clk); #1;
    chk("mid_re", 32'(mem_re), 32'd1);
    chk("mid_addr", mem_addr, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_re", 32'(mem_re), 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_dout", dout, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_resp", 32'(resp_valid), 32'd0);
      chk("abort_strobe", 32'(mem_we | mem_re), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_resp", 32'(resp_valid), 32'd0);
    do_req("lb6_post", 0, 1, 2'b00, 1, 32'h6, 32'h0, 3, 1, 32'hFFFF_FFFF);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
